// File: rtl/uart_receiver_pkg.sv
// Shared UART receiver definitions: frame size, FSM state encodings, parity helper.
package uart_receiver_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'b000,
        ST_START_BIT  = 3'b001,
        ST_DATA       = 3'b010,
        ST_PARITY_BIT = 3'b011,
        ST_STOP_BIT   = 3'b100
    } rx_state_t;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/uart_receiver_sync.sv
// Two-flop synchronizer for the asynchronous Rx pin; both flops preset to idle-high.
module uart_rx_sync (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 (even parity bit added when UART_RX_PARITY_EN is defined).
// Byte pulse arrives about 2 sync + H + 9 bit periods after the start-bit edge; no backpressure.
module uart_receiver #(
    parameter int CLK_PER_BIT   = 104,
    parameter int COUNTER_WIDTH = 7
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_data_out,
    output logic       o_data_valid,
    output logic       o_frame_error,
    output logic       o_parity_error,
    output logic       o_receiver_busy
);
    import uart_receiver_pkg::*;

    localparam logic [COUNTER_WIDTH-1:0] LP_HALF_M1 = COUNTER_WIDTH'(CLK_PER_BIT / 2 - 1);
    localparam logic [COUNTER_WIDTH-1:0] LP_FULL_M1 = COUNTER_WIDTH'(CLK_PER_BIT - 1);
    localparam logic [3:0]               LP_LAST_BIT = 4'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    rx_state_t                 r_state,     w_state_nxt;
    logic [COUNTER_WIDTH-1:0]  r_cnt,       w_cnt_nxt;
    logic [3:0]                r_bit_cnt,   w_bit_cnt_nxt;
    logic [7:0]                r_shift,     w_shift_nxt;
    logic [7:0]                r_data,      w_data_nxt;
    logic                      r_valid,     w_valid_nxt;
    logic                      r_ferr,      w_ferr_nxt;
    logic                      r_wait_high, w_wait_high_nxt;
`ifdef UART_RX_PARITY_EN
    logic                      r_perr,      w_perr_nxt;
    logic                      r_par_bad,   w_par_bad_nxt;
`endif

    uart_rx_sync u_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_rx),
        .o_sync    (w_rx_s)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_ferr_nxt      = 1'b0;
        w_wait_high_nxt = r_wait_high;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt      = 1'b0;
        w_par_bad_nxt   = r_par_bad;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt     = '0;
                w_bit_cnt_nxt = '0;
                // After a frame error the line must be seen high again before a new start.
                if (w_rx_s) begin
                    w_wait_high_nxt = 1'b0;
                end else if (!r_wait_high) begin
                    w_state_nxt = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                if (r_cnt == LP_HALF_M1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == LP_FULL_M1) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {w_rx_s, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == LP_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY_BIT;
`else
                        w_state_nxt = ST_STOP_BIT;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY_BIT: begin
                if (r_cnt == LP_FULL_M1) begin
                    w_cnt_nxt     = '0;
                    w_par_bad_nxt = (w_rx_s != even_parity(r_shift));
                    w_state_nxt   = ST_STOP_BIT;
                end
            end
`endif
            ST_STOP_BIT: begin
                // Leaving at mid-stop keeps half a bit of margin for a back-to-back start.
                if (r_cnt == LP_FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (!w_rx_s) begin
                        w_ferr_nxt      = 1'b1;
                        w_wait_high_nxt = 1'b1;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        if (r_par_bad) begin
                            w_perr_nxt = 1'b1;
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
                        end
`else
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_shift;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_wait_high <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr      <= 1'b0;
            r_par_bad   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_ferr      <= w_ferr_nxt;
            r_wait_high <= w_wait_high_nxt;
`ifdef UART_RX_PARITY_EN
            r_perr      <= w_perr_nxt;
            r_par_bad   <= w_par_bad_nxt;
`endif
        end
    end

    assign o_data_out      = r_data;
    assign o_data_valid    = r_valid;
    assign o_frame_error   = r_ferr;
    assign o_receiver_busy = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_error  = r_perr;
`else
    assign o_parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames against a byte-level model of the UART receiver.
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int CW  = 5;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif
    localparam int LAT_MAX = H + (HAS_PAR ? 10 : 9) * CPB + 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       parity_error;
    logic       busy;

    always #5 clk = ~clk;

    uart_receiver #(.CLK_PER_BIT(CPB), .COUNTER_WIDTH(CW)) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_rx            (rx),
        .o_data_out      (data_out),
        .o_data_valid    (data_valid),
        .o_frame_error   (frame_error),
        .o_parity_error  (parity_error),
        .o_receiver_busy (busy)
    );

    // Output monitor, sampled on the falling edge.
    int         cyc = 0;
    int         vld_cnt = 0, ferr_cnt = 0, perr_cnt = 0, excl_viol = 0, last_vld_cyc = 0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            vld_cnt      <= vld_cnt + 1;
            last_vld_cyc <= cyc;
            got_q.push_back(data_out);
        end
        if (frame_error)  ferr_cnt <= ferr_cnt + 1;
        if (parity_error) perr_cnt <= perr_cnt + 1;
        if (int'(data_valid) + int'(frame_error) + int'(parity_error) > 1)
            excl_viol <= excl_viol + 1;
    end

    // Byte-level reference model.
    logic [7:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;
    int         exp_ferr = 0, exp_perr = 0;

    int checks = 0, passes = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_flip);
        logic [10:0] f;
        if (HAS_PAR) f = {stop_ok, (^b) ^ par_flip, b, 1'b0};
        else         f = {1'b0, stop_ok, b, 1'b0};
        for (int i = 0; i < (HAS_PAR ? 11 : 10); i++) drive_bit(f[i]);
    endtask

    task automatic tx(input logic [7:0] b, input logic stop_ok, input logic par_flip);
        send_frame(b, stop_ok, par_flip);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (HAS_PAR && par_flip) begin
            exp_perr++;
        end else begin
            exp_q.push_back(b);
            exp_data = b;
        end
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * CPB) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int t0;
        int busy_cycles;
        logic [7:0] b;
        logic       ok;
        int         gap;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_ferr", frame_error, 1'b0);
        check("rst_perr", parity_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single good frame
        t0 = cyc;
        tx(8'hA5, 1'b1, 1'b0);
        idle(1);
        check("t1_data_out", data_out, 8'hA5);
        check("t1_valid_count", vld_cnt, 1);
        check("t1_busy_idle", busy, 1'b0);
        check("t1_latency_ok", (last_vld_cyc - t0) <= LAT_MAX, 1'b1);

        // Short glitch: false start, no pulse
        busy_cycles = 0;
        rx = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            if (i == 3) rx = 1'b1;
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        check("t2_busy_bounded", busy_cycles <= H + 3, 1'b1);
        check("t2_busy_seen", busy_cycles > 0, 1'b1);
        check("t2_no_valid", vld_cnt, exp_q.size());
        check("t2_no_ferr", ferr_cnt, 0);

        // Good byte, then a frame with a low stop bit
        tx(8'h11, 1'b1, 1'b0);
        idle(2);
        tx(8'h3C, 1'b0, 1'b0);
        idle(2);
        check("t3_ferr_count", ferr_cnt, exp_ferr);
        check("t3_data_held", data_out, 8'h11);
        check("t3_valid_count", vld_cnt, exp_q.size());

        // Back-to-back frames
        tx(8'h00, 1'b1, 1'b0);
        tx(8'hFF, 1'b1, 1'b0);
        tx(8'h5A, 1'b1, 1'b0);
        idle(2);
        check_stream("t4");

        // Reset in the middle of the 4th data bit
        b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx = b[3];
        repeat (H) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("t5_rst_data_out", data_out, 8'h00);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_valid", data_valid, 1'b0);
        check("t5_rst_ferr", frame_error, 1'b0);
        exp_data = 8'h00;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tx(8'h81, 1'b1, 1'b0);
        idle(2);
        check("t5_data_out", data_out, 8'h81);
        check_stream("t5");

        // Randomized frames, some with a bad stop bit
        for (int n = 0; n < 10; n++) begin
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            tx(b, ok, 1'b0);
            gap = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            idle(gap);
        end
        idle(2);
        check_stream("rand");
        check("rand_ferr_count", ferr_cnt, exp_ferr);
        check("rand_data_out", data_out, exp_data);

`ifdef UART_RX_PARITY_EN
        tx(8'h07, 1'b1, 1'b0);
        idle(2);
        check("t6_good_parity", data_out, 8'h07);
        tx(8'h07, 1'b1, 1'b1);
        idle(2);
        check("t6_perr_count", perr_cnt, exp_perr);
        tx(8'h3A, 1'b1, 1'b1);
        idle(2);
        check("t6_data_held", data_out, 8'h07);
        check_stream("t6");
`endif

        check("perr_total", perr_cnt, exp_perr);
        check("pulse_exclusive", excl_viol, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
